// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//   UART transmit stage that sits directly downstream of a baud-rate counter.
//   A parallel word is accepted through a valid/ready handshake and shifted out
//   LSB-first as a start / data / [parity] / stop frame. While a frame is in
//   flight, baud_en holds the counter running. The counter's overflow pulse
//   comes back as baud_tick and marks the last cycle of each serial bit.
//
// Parameters
//   DATA_W     data bits per frame (5..9)
//   PARITY_EN  1 = insert a parity bit after the data bits
//   PARITY_ODD 1 = odd parity, 0 = even parity
//   STOP_BITS  number of stop bits (1 or 2)
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-low
//   baud_tick  1-cycle pulse from the baud counter, last cycle of a bit
//   tx_data    word to send, sampled on the handshake edge
//   tx_valid   producer has a word
//   tx_ready   block can accept a word (registered)
//   baud_en    enable to the baud counter, high for the whole frame (registered)
//   tx         serial line, idle high (registered)
//   tx_busy    frame in progress (registered)
//   tx_done    1-cycle pulse in the last cycle of the final stop bit
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              baud_en,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic             ODD_BIT   = 1'(PARITY_ODD);
    localparam logic             PAR_ON    = 1'(PARITY_EN);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity of a data word; the odd/even selection is applied by the caller.
    function automatic logic parity_of(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    state_t            state_q,    state_d;
    logic [DATA_W-1:0] shift_q,    shift_d;
    logic              parity_q,   parity_d;
    logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              tx_q,       tx_d;
    logic              baud_en_q,  baud_en_d;
    logic              tx_ready_q, tx_ready_d;
    logic              tx_busy_q,  tx_busy_d;
    logic              tx_done_s;

    // State and output registers; reset drops the line high at once, even mid-frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            baud_en_q  <= 1'b0;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            baud_en_q  <= baud_en_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    // Next-state logic: frame sequencing, driven by baud_tick outside IDLE.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_done_s  = 1'b0;
        case (state_q)
            IDLE: begin
                // baud_tick is deliberately not looked at here.
                if (tx_valid && tx_ready_q) begin
                    shift_d    = tx_data;
                    parity_d   = parity_of(tx_data) ^ ODD_BIT;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = PAR_ON ? PARITY : STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        tx_done_s = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: registered outputs are computed from the next state, so they
    // line up with the state they describe instead of lagging by a cycle.
    always_comb begin
        tx_d       = 1'b1;
        baud_en_d  = (state_d != IDLE);
        tx_ready_d = (state_d == IDLE);
        tx_busy_d  = (state_d != IDLE);
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx       = tx_q;
    assign baud_en  = baud_en_q;
    assign tx_ready = tx_ready_q;
    assign tx_busy  = tx_busy_q;
    // tx_done has to sit inside the final stop bit's last cycle, so it is not registered.
    assign tx_done  = tx_done_s;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

    // Instance 0: 8N1, instance 1: 8E1, instance 2: 8O1, instance 3: 8N2 with tick always high
    localparam int PER [4] = '{4, 4, 4, 1};

    logic       clk;
    logic       rst;
    logic       baud_tick_s [4];
    logic [7:0] tx_data_s   [4];
    logic       tx_valid_s  [4];
    logic       tx_ready_s  [4];
    logic       baud_en_s   [4];
    logic       tx_s        [4];
    logic       tx_busy_s   [4];
    logic       tx_done_s   [4];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_serializer #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick_s[0]), .tx_data(tx_data_s[0]),
        .tx_valid(tx_valid_s[0]), .tx_ready(tx_ready_s[0]), .baud_en(baud_en_s[0]),
        .tx(tx_s[0]), .tx_busy(tx_busy_s[0]), .tx_done(tx_done_s[0]));

    uart_tx_serializer #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick_s[1]), .tx_data(tx_data_s[1]),
        .tx_valid(tx_valid_s[1]), .tx_ready(tx_ready_s[1]), .baud_en(baud_en_s[1]),
        .tx(tx_s[1]), .tx_busy(tx_busy_s[1]), .tx_done(tx_done_s[1]));

    uart_tx_serializer #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick_s[2]), .tx_data(tx_data_s[2]),
        .tx_valid(tx_valid_s[2]), .tx_ready(tx_ready_s[2]), .baud_en(baud_en_s[2]),
        .tx(tx_s[2]), .tx_busy(tx_busy_s[2]), .tx_done(tx_done_s[2]));

    uart_tx_serializer #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick_s[3]), .tx_data(tx_data_s[3]),
        .tx_valid(tx_valid_s[3]), .tx_ready(tx_ready_s[3]), .baud_en(baud_en_s[3]),
        .tx(tx_s[3]), .tx_busy(tx_busy_s[3]), .tx_done(tx_done_s[3]));

    // Baud counter model: counts while enabled, cleared while disabled, ovf on PER-1.
    for (genvar g = 0; g < 4; g++) begin : g_baud
        int cnt = 0;
        always @(posedge clk) begin
            if (!baud_en_s[g])            cnt <= 0;
            else if (cnt == PER[g] - 1)   cnt <= 0;
            else                          cnt <= cnt + 1;
        end
        assign baud_tick_s[g] = (PER[g] == 1) ? 1'b1 : (baud_en_s[g] && (cnt == PER[g] - 1));
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int idx, input string tag);
        chk($sformatf("%s_tx%0d", tag, idx),      tx_s[idx],       1'b1);
        chk($sformatf("%s_ready%0d", tag, idx),   tx_ready_s[idx], 1'b1);
        chk($sformatf("%s_baud_en%0d", tag, idx), baud_en_s[idx],  1'b0);
        chk($sformatf("%s_busy%0d", tag, idx),    tx_busy_s[idx],  1'b0);
        chk($sformatf("%s_done%0d", tag, idx),    tx_done_s[idx],  1'b0);
    endtask

    // Called just after a negedge while the instance is idle. bits[k] is the k-th
    // serial bit (start first). Ends at the negedge of the idle cycle after the frame.
    task automatic run_frame(input int idx, input logic [7:0] data, input int n,
                             input int nbits, input logic [11:0] bits,
                             input bit keep_valid, input logic [7:0] next_data,
                             input bit toggle);
        tx_valid_s[idx] = 1'b1;
        tx_data_s[idx]  = data;
        chk($sformatf("ready_pre%0d", idx), tx_ready_s[idx], 1'b1);
        @(posedge clk);
        @(negedge clk);
        if (keep_valid) tx_data_s[idx] = next_data;
        else            tx_valid_s[idx] = 1'b0;
        for (int cyc = 1; cyc <= nbits * n; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (toggle) tx_data_s[idx] = ~tx_data_s[idx];
            chk($sformatf("tx%0d_d%02h_c%0d", idx, data, cyc), tx_s[idx], bits[(cyc - 1) / n]);
            chk($sformatf("done%0d_d%02h_c%0d", idx, data, cyc), tx_done_s[idx],
                (cyc == nbits * n) ? 1'b1 : 1'b0);
            chk($sformatf("baud_en%0d_d%02h_c%0d", idx, data, cyc), baud_en_s[idx], 1'b1);
            chk($sformatf("ready%0d_d%02h_c%0d", idx, data, cyc), tx_ready_s[idx], 1'b0);
        end
        @(negedge clk);
        chk_idle(idx, "post");
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_valid_s[i] = 1'b0;
            tx_data_s[i]  = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) chk_idle(i, "reset");
        rst = 1'b1;

        // Idle for 20 cycles: line high, ready, counter disabled, no done
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk_idle(0, $sformatf("idle%0d", c));
        end

        // 0xA5 8N1: 0,1,0,1,0,0,1,0,1,1
        run_frame(0, 8'hA5, 4, 10, 12'h34A, 1'b0, 8'h00, 1'b0);
        // 0xA5 8E1: 0,1,0,1,0,0,1,0,1, parity 0, stop 1 (44 cycles)
        run_frame(1, 8'hA5, 4, 11, 12'h54A, 1'b0, 8'h00, 1'b0);
        // 0xA5 8O1: same with parity 1
        run_frame(2, 8'hA5, 4, 11, 12'h74A, 1'b0, 8'h00, 1'b0);

        // Back-to-back 0x3C then 0xFF, tx_valid held high across both
        run_frame(0, 8'h3C, 4, 10, 12'h278, 1'b1, 8'hFF, 1'b0);
        run_frame(0, 8'hFF, 4, 10, 12'h3FE, 1'b0, 8'h00, 1'b0);

        // Reset during the 3rd data bit (cycles 13..16) of 0x00
        tx_valid_s[0] = 1'b1;
        tx_data_s[0]  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        tx_valid_s[0] = 1'b0;
        repeat (13) @(negedge clk);
        chk("abort_pre_tx", tx_s[0], 1'b0);
        chk("abort_pre_baud_en", baud_en_s[0], 1'b1);
        rst = 1'b0;
        #1;
        chk_idle(0, "abort_now");
        @(negedge clk);
        chk_idle(0, "abort_hold");
        rst = 1'b1;
        @(negedge clk);
        chk_idle(0, "abort_rel");
        // 0x55 8N1: 0,1,0,1,0,1,0,1,0,1
        run_frame(0, 8'h55, 4, 10, 12'h2AA, 1'b0, 8'h00, 1'b0);

        // 8N2 with tick always high: 0x96 -> 0,0,1,1,0,1,0,0,1,1,1 (11 cycles), data toggling
        run_frame(3, 8'h96, 1, 11, 12'h72C, 1'b0, 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
